// File: rtl/aspen_pkg.sv
// Shared definitions for the tile scheduler.
//   state_e          : scheduler FSM state encoding
//   MSG_*            : bit positions inside one tile's control message
//   chunk_beats()    : beats per chunk for a given chunk-counter width
//   compute_cycles() : length of a COMPUTE pause between chunks
//   drain_cycles()   : length of the DRAIN phase
//   msg_word()       : builds one tile's 4-bit {finished, memSD, memReady, run} message
package aspen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STREAM  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_STORE   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam int MSG_RUN      = 0;
  localparam int MSG_MEMREADY = 1;
  localparam int MSG_MEMSD    = 2;
  localparam int MSG_FINISHED = 3;

  localparam int BEAT_W = 16;
  localparam int CYC_W  = 16;

  function automatic int chunk_beats(input int num_counters);
    return (1 << num_counters) - 2;
  endfunction

  function automatic int compute_cycles(input int size_tile);
    return size_tile + 1;
  endfunction

  function automatic int drain_cycles(input int size_tile);
    return 2 * size_tile + 2;
  endfunction

  function automatic logic [3:0] msg_word(input logic finished, input logic mem_sd,
                                          input logic mem_rdy, input logic run);
    logic [3:0] w;
    w               = '0;
    w[MSG_FINISHED] = finished;
    w[MSG_MEMSD]    = mem_sd;
    w[MSG_MEMREADY] = mem_rdy;
    w[MSG_RUN]      = run;
    return w;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat and chunk counting for one timestep.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : clear both counters (start of a timestep)
//   clr_chunk_i    : clear only the chunk counter (end of a COMPUTE pause)
//   en_i           : one beat accepted this cycle
//   target_i       : total beats for this timestep
//   last_o         : the beat accepted now (if any) is the final one
//   chunk_full_o   : the beat accepted now (if any) completes a chunk
module beat_counter
  import aspen_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int CHUNK = 30
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              clr_chunk_i,
  input  logic              en_i,
  input  logic [BEAT_W-1:0] target_i,
  output logic              last_o,
  output logic              chunk_full_o
);

  localparam logic [CNT_W:0] CHUNK_V = (CNT_W + 1)'(CHUNK);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  chunk_q, chunk_d;

  always_comb begin
    beat_d  = beat_q;
    chunk_d = chunk_q;
    if (clr_i) begin
      beat_d  = '0;
      chunk_d = '0;
    end else begin
      if (clr_chunk_i) chunk_d = '0;
      // Saturating: the beat count never wraps past all-ones.
      if (en_i && (beat_q != '1)) begin
        beat_d = beat_q + 1'b1;
        if (chunk_q != '1) chunk_d = chunk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      chunk_q <= '0;
    end else begin
      beat_q  <= beat_d;
      chunk_q <= chunk_d;
    end
  end

  // Flags look ahead by one beat so the FSM can leave STREAM on the
  // same edge that accepts the terminal beat. Widened to avoid wrap.
  assign last_o       = ({1'b0, beat_q} + 17'd1) == {1'b0, target_i};
  assign chunk_full_o = ({1'b0, chunk_q} + 1'b1) == CHUNK_V;

endmodule

// File: rtl/tile_scheduler.sv
// Sequences one timestep across NUM_TILES neuron tiles sharing a vmem port
// and a data bus.
//   clk, reset        : clock, asynchronous active-low reset
//   start, num_beats  : begin a timestep of num_beats data beats (IDLE only)
//   mem_valid/ready   : shared data bus handshake; mem_ready marks a consumed beat
//   msgControl        : per-tile {finished, memSD, memReady, run}, tile 0 in LSBs
//   tile_sel          : tile owning the vmem port (LOAD/STORE), else 0
//   vmem_rd, vmem_wr  : vmem load / store strobes
//   busy, done        : not idle / one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start, all tiles stopped
// LOAD    | one cycle per tile, loading its vmem contents
// STREAM  | broadcasting data beats to every tile
// COMPUTE | pause after a full chunk so tiles can integrate
// DRAIN   | tiles finish their last chunk
// STORE   | one cycle per tile, writing vmem back
// DONE    | completion pulse, then back to IDLE
module tile_scheduler
  import aspen_pkg::*;
#(
  parameter int NUM_TILES    = 4,
  parameter int size_control = 4,
  parameter int size_tile    = 4,
  parameter int num_counters = 5
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [15:0]                                     num_beats,
  input  logic                                            mem_valid,
  output logic                                            mem_ready,
  output logic [NUM_TILES*size_control-1:0]               msgControl,
  output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0] tile_sel,
  output logic                                            vmem_rd,
  output logic                                            vmem_wr,
  output logic                                            busy,
  output logic                                            done
);

  localparam int SEL_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int MSG_W = NUM_TILES * size_control;
  localparam int CHUNK = chunk_beats(num_counters);

  localparam logic [CYC_W-1:0] TILE_LAST    = CYC_W'(NUM_TILES - 1);
  localparam logic [CYC_W-1:0] COMPUTE_LAST = CYC_W'(compute_cycles(size_tile) - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST   = CYC_W'(drain_cycles(size_tile) - 1);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BEAT_W-1:0] nb_q, nb_d;

  logic              cnt_clr, cnt_clr_chunk, accept;
  logic              last_beat, chunk_full;

  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              stream_q, stream_d;
  int                k_d;

  beat_counter #(
    .CNT_W (num_counters),
    .CHUNK (CHUNK)
  ) u_beats (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clr_i        (cnt_clr),
    .clr_chunk_i  (cnt_clr_chunk),
    .en_i         (accept),
    .target_i     (nb_q),
    .last_o       (last_beat),
    .chunk_full_o (chunk_full)
  );

  // Next-state logic. cyc_q is a down-counter holding remaining cycles - 1.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    nb_d          = nb_q;
    cnt_clr       = 1'b0;
    cnt_clr_chunk = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nb_d    = num_beats;
          cnt_clr = 1'b1;
          if (num_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            cyc_d   = TILE_LAST;
          end
        end
      end
      ST_LOAD: begin
        if (cyc_q == '0) state_d = ST_STREAM;
        else             cyc_d   = cyc_q - 1'b1;
      end
      ST_STREAM: begin
        if (mem_valid) begin
          accept = 1'b1;
          // A final beat that also fills a chunk goes straight to DRAIN.
          if (last_beat) begin
            state_d = ST_DRAIN;
            cyc_d   = DRAIN_LAST;
          end else if (chunk_full) begin
            state_d = ST_COMPUTE;
            cyc_d   = COMPUTE_LAST;
          end
        end
      end
      ST_COMPUTE: begin
        if (cyc_q == '0) begin
          state_d       = ST_STREAM;
          cnt_clr_chunk = 1'b1;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cyc_q == '0) begin
          state_d = ST_STORE;
          cyc_d   = TILE_LAST;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      ST_STORE: begin
        if (cyc_q == '0) state_d = ST_DONE;
        else             cyc_d   = cyc_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    msg_d    = '0;
    sel_d    = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    stream_d = (state_d == ST_STREAM);
    k_d      = NUM_TILES - 1 - int'(cyc_d);
    for (int t = 0; t < NUM_TILES; t++) begin
      unique case (state_d)
        ST_LOAD:    msg_d[t*size_control +: 4] = (t == k_d) ? msg_word(1'b0, 1'b0, 1'b1, 1'b1)
                                                            : msg_word(1'b0, 1'b0, 1'b0, 1'b1);
        ST_STREAM:  msg_d[t*size_control +: 4] = msg_word(1'b0, 1'b1, 1'b0, 1'b1);
        ST_COMPUTE: msg_d[t*size_control +: 4] = msg_word(1'b0, 1'b0, 1'b0, 1'b1);
        ST_DRAIN:   msg_d[t*size_control +: 4] = msg_word(1'b1, 1'b0, 1'b0, 1'b1);
        ST_STORE:   msg_d[t*size_control +: 4] = msg_word(1'b0, 1'b0, 1'b0, 1'b1);
        default:    msg_d[t*size_control +: 4] = 4'b0000;
      endcase
    end
    if (state_d == ST_LOAD) begin
      sel_d = SEL_W'(k_d);
      rd_d  = 1'b1;
    end
    if (state_d == ST_STORE) begin
      sel_d = SEL_W'(k_d);
      wr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      nb_q     <= '0;
      msg_q    <= '0;
      sel_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stream_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      nb_q     <= nb_d;
      msg_q    <= msg_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stream_q <= stream_d;
    end
  end

  // The handshake must report the beat taken in this very cycle, so it is
  // the only output gated by a live input (a flop AND mem_valid).
  assign mem_ready = stream_q & mem_valid;

  always_comb begin
    msgControl = msg_q;
    for (int t = 0; t < NUM_TILES; t++) begin
      msgControl[t*size_control + MSG_MEMREADY] = msg_q[t*size_control + MSG_MEMREADY] | mem_ready;
    end
  end

  assign tile_sel = sel_q;
  assign vmem_rd  = rd_q;
  assign vmem_wr  = wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

  localparam int NT    = 4;
  localparam int SC    = 4;
  localparam int STL   = 4;
  localparam int NC    = 5;
  localparam int CHUNK = (1 << NC) - 2;
  localparam int NCOMP = STL + 1;
  localparam int NDRN  = 2 * STL + 2;
  localparam int OW    = NT * SC + 2 + 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_beats = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [NT*SC-1:0] msgControl;
  logic [1:0]    tile_sel;
  logic          vmem_rd, vmem_wr, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  tile_scheduler #(
    .NUM_TILES    (NT),
    .size_control (SC),
    .size_tile    (STL),
    .num_counters (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_beats  (num_beats),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .msgControl (msgControl),
    .tile_sel   (tile_sel),
    .vmem_rd    (vmem_rd),
    .vmem_wr    (vmem_wr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_LOAD, P_STREAM, P_COMPUTE, P_DRAIN, P_STORE, P_DONE} phase_e;
  typedef struct {
    phase_e ph;
    int     k;
    bit     mv;
    int     beatno;
  } ent_t;

  ent_t tr[$];

  function automatic logic [OW-1:0] observed();
    return {msgControl, tile_sel, vmem_rd, vmem_wr, mem_ready, busy, done};
  endfunction

  // Expected outputs of one cycle, straight from the phase description:
  // message nibble is {finished, memSD, memReady, run}.
  function automatic logic [OW-1:0] expected(input phase_e ph, input int k, input bit mv);
    logic [NT*SC-1:0] m;
    logic [1:0] sel;
    logic rd, wr, rdy, bsy, dn;
    m = '0; sel = '0; rd = 0; wr = 0; rdy = 0; bsy = (ph != P_IDLE); dn = (ph == P_DONE);
    for (int t = 0; t < NT; t++) begin
      case (ph)
        P_LOAD:    m[t*SC +: 4] = (t == k) ? 4'b0011 : 4'b0001;
        P_STREAM:  m[t*SC +: 4] = {1'b0, 1'b1, mv, 1'b1};
        P_COMPUTE: m[t*SC +: 4] = 4'b0001;
        P_DRAIN:   m[t*SC +: 4] = 4'b1001;
        P_STORE:   m[t*SC +: 4] = 4'b0001;
        default:   m[t*SC +: 4] = 4'b0000;
      endcase
    end
    if (ph == P_LOAD)   begin sel = 2'(k); rd = 1; end
    if (ph == P_STORE)  begin sel = 2'(k); wr = 1; end
    if (ph == P_STREAM) rdy = mv;
    return {m, sel, rd, wr, rdy, bsy, dn};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_mv(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return (idx % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic push(input phase_e ph, input int k, input bit mv, input int bn);
    ent_t e;
    e.ph = ph; e.k = k; e.mv = mv; e.beatno = bn;
    tr.push_back(e);
  endtask

  // Builds the whole expected timestep as a per-cycle list of phases.
  task automatic build(input int nb, input int mode);
    int beats, chunk, idx;
    bit mv;
    tr.delete();
    if (nb == 0) begin
      push(P_DONE, 0, 1'($urandom), 0);
      return;
    end
    for (int k = 0; k < NT; k++) push(P_LOAD, k, 1'($urandom), 0);
    beats = 0; chunk = 0; idx = 0;
    while (beats < nb) begin
      mv = pick_mv(mode, idx);
      idx++;
      push(P_STREAM, 0, mv, beats + int'(mv));
      if (mv) begin
        beats++;
        chunk++;
        if (beats < nb && chunk == CHUNK) begin
          for (int c = 0; c < NCOMP; c++) push(P_COMPUTE, 0, 1'($urandom), beats);
          chunk = 0;
        end
      end
    end
    for (int d = 0; d < NDRN; d++) push(P_DRAIN, 0, 1'($urandom), beats);
    for (int k = 0; k < NT; k++) push(P_STORE, k, 1'($urandom), beats);
    push(P_DONE, 0, 1'($urandom), beats);
  endtask

  task automatic run_timestep(input int ts, input int nb, input int mode, input int abort_beat);
    bit aborted;
    aborted = 0;
    build(nb, mode);
    start     = 1'b1;
    num_beats = 16'(nb);
    mem_valid = 1'($urandom);
    @(posedge clk);
    for (int j = 0; j < tr.size(); j++) begin
      #1;
      mem_valid = tr[j].mv;
      start     = 1'($urandom);
      num_beats = 16'($urandom);
      #1;
      chk($sformatf("ts%0d_%s_%0d", ts, tr[j].ph.name(), j), observed(),
          expected(tr[j].ph, tr[j].k, tr[j].mv));
      if (abort_beat > 0 && tr[j].ph == P_STREAM && tr[j].mv && tr[j].beatno == abort_beat) begin
        #1 reset = 1'b0;
        #1 chk($sformatf("ts%0d_async_reset", ts), observed(), '0);
        repeat (2) @(posedge clk);
        #1 chk($sformatf("ts%0d_reset_hold", ts), observed(), '0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        aborted = 1;
        break;
      end
      @(posedge clk);
    end
    if (!aborted) begin
      #1;
      start     = 1'b0;
      mem_valid = 1'($urandom);
      #1 chk($sformatf("ts%0d_idle_after", ts), observed(), expected(P_IDLE, 0, mem_valid));
    end
  endtask

  initial begin
    mem_valid = 1'b1;
    start     = 1'b1;
    num_beats = 16'd7;
    #2 reset = 1'b0;
    #1 chk("reset_async", observed(), '0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", observed(), '0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2 chk("reset_release_idle", observed(), expected(P_IDLE, 0, mem_valid));

    run_timestep(1, 10, 0, 0);    // basic full run
    run_timestep(2, 65, 0, 0);    // two COMPUTE pauses
    run_timestep(3, 30, 0, 0);    // last beat fills a chunk
    run_timestep(4, 60, 0, 0);    // last beat fills the second chunk
    run_timestep(5, 31, 0, 0);    // one beat past a chunk
    run_timestep(6, 12, 1, 0);    // mem_valid 1,0,0 pattern
    run_timestep(7, 10, 0, 5);    // reset during beat 5
    run_timestep(8, 10, 0, 0);    // clean run after the abort
    run_timestep(9, 0, 0, 0);     // empty timestep
    for (int r = 0; r < 5; r++) begin
      run_timestep(10 + r, int'($urandom_range(1, 100)), 2, 0);
    end
    run_timestep(20, 65, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameter NUM_TILES, default 4: number of neuron tiles sequenced.
REQ-002 Parameter size_control, default 4: control message width per tile.
REQ-003 Parameter size_tile, default 4: neurons per tile.
REQ-004 Parameter num_counters, default 5: tile counter width; CHUNK = 2^num_counters-2 beats.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: begin one timestep; sampled only in IDLE.
REQ-008 Port num_beats, input, 16: data beats this timestep; captured on start.
REQ-009 Port mem_valid, input, 1: shared data bus holds a beat.
REQ-010 Port mem_ready, output, 1: beat consumed this cycle (mem_valid and STREAM).
REQ-011 Port msgControl, output, NUM_TILES*size_control: per tile {finished, memSD, memReady, run}, with run at bit 0.
REQ-012 Port tile_sel, output, clog2(NUM_TILES): tile owning the shared vmem port.
REQ-013 Port vmem_rd / vmem_wr, output, 1 each: vmem port read (load) and write (store) strobes.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when the timestep completes.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, STREAM, COMPUTE, DRAIN, STORE, DONE; all outputs are registered.
REQ-017 In IDLE, all run bits SHALL be 0; start=1 with num_beats>0 SHALL go to LOAD; start with num_beats=0 SHALL go directly to DONE.
REQ-018 LOAD SHALL last NUM_TILES cycles; in cycle k: tile_sel=k, vmem_rd=1, tile k gets {0,0,1,1}, other tiles get {0,0,0,1}; then go to STREAM.
REQ-019 In STREAM, all tiles SHALL get memReady=mem_valid and memSD=1; a beat counts only when mem_valid=1; mem_valid=0 stalls with no state change.
REQ-020 The chunk counter SHALL increment per accepted beat; at CHUNK beats with beats still remaining, go to COMPUTE.
REQ-021 COMPUTE SHALL hold memReady=0 and finished=0 for size_tile+1 cycles, clear the chunk counter, then return to STREAM.
REQ-022 After the last beat (total = num_beats), go to DRAIN; DRAIN SHALL assert finished=1 to all tiles for 2*size_tile+2 cycles.
REQ-023 STORE SHALL last NUM_TILES cycles, with tile_sel=k and vmem_wr=1 in cycle k; then go to DONE.
REQ-024 DONE SHALL pulse done=1 for one cycle, drive run=0, and return to IDLE.
REQ-025 The beat counter SHALL be 16 bits, compared for equality, and never wrap; beats that arrive outside STREAM are not accepted.
REQ-026 start outside IDLE SHALL be ignored; num_beats changes after capture SHALL have no effect.
REQ-027 When the last beat also fills a chunk, the FSM SHALL go to DRAIN, not COMPUTE.
REQ-028 vmem_rd and vmem_wr SHALL never be high together; outside LOAD/STORE, tile_sel=0.

Reset
REQ-029 reset=0 SHALL force, immediately and regardless of clk, state=IDLE, every counter=0, msgControl=0, tile_sel=0, vmem_rd=vmem_wr=mem_ready=busy=done=0.
REQ-030 Reset asserted mid-timestep SHALL abandon the timestep with no store and no done pulse.

Structure
REQ-031 The state encoding, the message bit indices (run=0, memReady=1, memSD=2, finished=3), and the CHUNK and cycle-count formulas SHALL live in a shared package, aspen_pkg.
REQ-032 The beat/chunk counting SHALL be a single sub-module, beat_counter (enable, clear, terminal-count flags).

Verification
REQ-033 Reset then start, num_beats=10, mem_valid=1 throughout: LOAD 4 cycles (tile_sel 0..3), 10 mem_ready cycles, DRAIN 10 cycles, STORE 4 cycles, done pulses once.
REQ-034 num_beats=65, num_counters=5: COMPUTE entered after beat 30 and again after beat 60, each time 5 cycles with memReady=0; DRAIN after beat 65.
REQ-035 num_beats=30: the last beat fills a chunk, so go straight to DRAIN with no COMPUTE.
REQ-036 mem_valid toggling 1,0,0,1...: the beat count advances only on the high cycles; memReady mirrors mem_valid.
REQ-037 Assert reset during STREAM beat 5: all outputs are 0 asynchronously, and the next start runs a full clean timestep.
REQ-038 start with num_beats=0: busy for 1 cycle, done pulses, and no vmem_rd or vmem_wr.
